// File: rtl/syscall_controller_if.sv
// CPU-side syscall bus: instruction decode flags in, stall enable and system input value out.
// master = CPU core, slave = syscall_controller.
interface syscall_controller_if #(
  parameter int OP_W = 2
);
  logic            syscall;
  logic [OP_W-1:0] sys_op;
  logic            halt;
  logic [31:0]     sys_out;
  logic            cpu_en;
  logic [31:0]     sys_in;

  // No valid/ready pair: the CPU presents a decoded instruction every cycle and
  // treats cpu_en=0 as "not ready"; the instruction is held until cpu_en returns to 1.
  modport master (
    output syscall, sys_op, halt, sys_out,
    input  cpu_en, sys_in
  );

  modport slave (
    input  syscall, sys_op, halt, sys_out,
    output cpu_en, sys_in
  );
endinterface

// File: rtl/syscall_controller.sv
// Syscall controller: stalls the CPU for switch input, drives a print display, latches halt.
// Optional input-wait timeout compiled in with `define SYSCTL_INPUT_TIMEOUT_EN.
module syscall_controller #(
  parameter int              OP_W           = 2,
  parameter logic [OP_W-1:0] OP_READ        = OP_W'(1),
  parameter logic [OP_W-1:0] OP_PRINT       = OP_W'(2),
  parameter logic [31:0]     TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  syscall_controller_if.slave   cpu,
  input  logic [31:0]           sw_data,
  input  logic                  confirm_btn,
  output logic [31:0]           disp_data,
  output logic                  disp_valid,
  output logic                  waiting_input,
  output logic                  halted,
  output logic [31:0]           retired,
  output logic                  timeout_flag,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_IN = 2'd1,
    LOAD    = 2'd2,
    HALT    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        btn_edge;
  logic [31:0] sys_in_q, sys_in_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic        disp_valid_q, disp_valid_d;
  logic [31:0] retired_q, retired_d;
  logic        cpu_en_c;

`ifdef SYSCTL_INPUT_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // sync3 is a history flop so a held button produces a single edge.
  assign btn_edge = sync2_q & ~sync3_q;

  always_comb begin
    state_d      = state_q;
    sys_in_d     = sys_in_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    cpu_en_c     = 1'b0;
`ifdef SYSCTL_INPUT_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      RUN: begin
        cpu_en_c = 1'b1;
        if (cpu.halt) begin
          cpu_en_c = 1'b0;
          state_d  = HALT;
        end else if (cpu.syscall && cpu.sys_op == OP_READ) begin
          cpu_en_c = 1'b0;
          state_d  = WAIT_IN;
`ifdef SYSCTL_INPUT_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else if (cpu.syscall && cpu.sys_op == OP_PRINT) begin
          disp_data_d  = cpu.sys_out;
          disp_valid_d = 1'b1;
        end
      end
      WAIT_IN: begin
        // A button edge beats a timeout landing in the same cycle.
        if (btn_edge) begin
          sys_in_d = sw_data;
          state_d  = LOAD;
        end
`ifdef SYSCTL_INPUT_TIMEOUT_EN
        else if (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
          sys_in_d  = '0;
          timeout_d = 1'b1;
          state_d   = LOAD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
`endif
      end
      LOAD: begin
        cpu_en_c = 1'b1;
        state_d  = RUN;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = RUN;
    endcase
    // The CPU's own synchronous reset needs an enabled clock to take effect.
    if (rst) cpu_en_c = 1'b1;
    retired_d = cpu_en_c ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      sys_in_q     <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      retired_q    <= '0;
`ifdef SYSCTL_INPUT_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= confirm_btn;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      sys_in_q     <= sys_in_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      retired_q    <= retired_d;
`ifdef SYSCTL_INPUT_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

`ifdef SYSCTL_INPUT_TIMEOUT_EN
  assign timeout_flag = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_flag   = 1'b0;
`endif

  assign cpu.cpu_en    = cpu_en_c;
  assign cpu.sys_in    = sys_in_q;
  assign disp_data     = disp_data_q;
  assign disp_valid    = disp_valid_q;
  assign retired       = retired_q;
  assign waiting_input = (state_q == WAIT_IN);
  assign halted        = (state_q == HALT);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_syscall_controller.sv
// Bench for syscall_controller: directed scenarios then random instruction streams,
// every cycle checked against a behavioural model of the controller.
module tb_syscall_controller;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_PRINT = 2'd2;
  localparam int M_RUN = 0, M_WAIT = 1, M_LOAD = 2, M_HALT = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] sw_data;
  logic        confirm_btn;
  logic [31:0] disp_data, retired;
  logic        disp_valid, waiting_input, halted, timeout_flag;
  logic [1:0]  dbg_state;

  syscall_controller_if #(.OP_W(2)) bus ();

  syscall_controller dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (bus.slave),
    .sw_data      (sw_data),
    .confirm_btn  (confirm_btn),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid),
    .waiting_input(waiting_input),
    .halted       (halted),
    .retired      (retired),
    .timeout_flag (timeout_flag),
    .dbg_state    (dbg_state)
  );

  // reference model
  int          m_mode;
  logic [31:0] m_sys_in, m_disp, m_ret;
  logic        m_dv;
  bit          btn_hist[$];   // oldest first: raw button samples from previous edges

  int compared = 0;
  int failed   = 0;
  logic obs_en, obs_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_en();
    if (rst) return 1'b1;
    case (m_mode)
      M_RUN:   return !(bus.halt || (bus.syscall && bus.sys_op == OP_READ));
      M_LOAD:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_mode = M_RUN; m_sys_in = 0; m_disp = 0; m_ret = 0; m_dv = 0;
    btn_hist = '{0, 0, 0};
  endfunction

  function automatic void model_step(input logic en);
    bit press;
    if (rst) begin
      model_reset();
      return;
    end
    // A press is visible two edges after the button first reads high.
    press = btn_hist[1] && !btn_hist[0];
    if (en) m_ret = m_ret + 32'd1;
    m_dv = 1'b0;
    case (m_mode)
      M_RUN: begin
        if (bus.halt) m_mode = M_HALT;
        else if (bus.syscall && bus.sys_op == OP_READ) m_mode = M_WAIT;
        else if (bus.syscall && bus.sys_op == OP_PRINT) begin
          m_disp = bus.sys_out;
          m_dv   = 1'b1;
        end
      end
      M_WAIT: if (press) begin
        m_sys_in = sw_data;
        m_mode   = M_LOAD;
      end
      M_LOAD: m_mode = M_RUN;
      default: m_mode = M_HALT;
    endcase
    void'(btn_hist.pop_front());
    btn_hist.push_back(confirm_btn);
  endfunction

  // driver: inputs are set after a falling edge; tick checks the stall
  // enable before the rising edge and the registered outputs just after it.
  task automatic tick();
    logic en;
    #1;
    en = model_en();
    obs_en = bus.cpu_en;
    chk("cpu_en", {31'd0, bus.cpu_en}, {31'd0, en});
    @(posedge clk);
    model_step(en);
    #1;
    obs_dv = disp_valid;
    chk("sys_in",        bus.sys_in, m_sys_in);
    chk("disp_data",     disp_data, m_disp);
    chk("disp_valid",    {31'd0, disp_valid}, {31'd0, m_dv});
    chk("waiting_input", {31'd0, waiting_input}, {31'd0, (m_mode == M_WAIT)});
    chk("halted",        {31'd0, halted}, {31'd0, (m_mode == M_HALT)});
    chk("retired",       retired, m_ret);
    chk("timeout_flag",  {31'd0, timeout_flag}, 32'd0);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.syscall = 0; bus.sys_op = 0; bus.halt = 0; bus.sys_out = 0;
  endtask

  initial begin
    int lat, pulses;
    model_reset();
    rst = 1; idle_inputs(); sw_data = 0; confirm_btn = 0;
    @(negedge clk);
    tick(); tick();
    rst = 0;

    // idle run after reset
    for (int i = 0; i < 10; i++) tick();
    chk("retired_after_10", retired, 32'd10);
    chk("halted_after_10", {31'd0, halted}, 32'd0);

    // read syscall answered by a button press three cycles later
    bus.syscall = 1; bus.sys_op = OP_READ; sw_data = 32'h0000_00A5;
    tick();
    chk("read_stall", {31'd0, obs_en}, 32'd0);
    idle_inputs();
    tick(); tick();
    confirm_btn = 1;
    lat = -1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) confirm_btn = 0;
      tick();
      if (obs_en && lat < 0) lat = i;
    end
    chk("load_latency_ok", {31'd0, (lat >= 1 && lat <= 3)}, 32'd1);
    chk("sys_in_a5", bus.sys_in, 32'h0000_00A5);

    // back-to-back prints
    pulses = 0;
    bus.syscall = 1; bus.sys_op = OP_PRINT; bus.sys_out = 32'd7;
    tick(); pulses += obs_dv;
    chk("print1_no_stall", {31'd0, obs_en}, 32'd1);
    bus.sys_out = 32'd9;
    tick(); pulses += obs_dv;
    chk("print2_no_stall", {31'd0, obs_en}, 32'd1);
    idle_inputs();
    tick(); pulses += obs_dv;
    chk("print_pulses", pulses, 32'd2);
    chk("print_last", disp_data, 32'd9);

    // halt wins over a simultaneous read; button ignored while halted
    bus.halt = 1; bus.syscall = 1; bus.sys_op = OP_READ;
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      confirm_btn = (i >= 2 && i < 5);
      tick();
    end
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_not_waiting", {31'd0, waiting_input}, 32'd0);
    chk("halt_stalled", {31'd0, obs_en}, 32'd0);
    rst = 1; tick(); rst = 0;
    chk("halt_rst_released", {31'd0, halted}, 32'd0);
    tick();

    // reset in the middle of an input wait
    bus.syscall = 1; bus.sys_op = OP_READ; sw_data = 32'hDEAD_BEEF;
    tick(); idle_inputs();
    tick(); tick();
    rst = 1; confirm_btn = 1;
    tick();
    chk("rst_wait_sys_in", bus.sys_in, 32'd0);
    chk("rst_wait_not_waiting", {31'd0, waiting_input}, 32'd0);
    rst = 0; confirm_btn = 0;
    tick();
    chk("rst_wait_run", {31'd0, obs_en}, 32'd1);

    // random instruction streams
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      bus.halt    = ($urandom_range(0, 79) == 0);
      bus.syscall = ($urandom_range(0, 2) == 0);
      bus.sys_op  = 2'($urandom_range(0, 3));
      bus.sys_out = $urandom;
      sw_data     = $urandom;
      if ($urandom_range(0, 3) == 0) confirm_btn = ~confirm_btn;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
